keccak_sponge_ctrl: RTL
=======================

// Module: keccak_sponge_ctrl
// PURPOSE
//  Sponge controller upstream and downstream of keccak_f1600: absorbs 64-bit message words, applies pad10*1
//  with a domain byte, runs the permutation via start/done, then squeezes rate lanes as 64-bit words.
//  Serves SHA3/SHAKE users in KEM (hash G/H/J, XOF for matrix and noise sampling).
// PARAMETERS
//  RATE_BYTES  168    rate in bytes (168=SHAKE128, 136=SHA3-256/SHAKE256, 72=SHA3-512); multiple of 8, <=168
//  DSBYTE      8'h1F  domain-separation byte XORed after the message (8'h06 for SHA3)
// PORTS
//  clk         in   1     clock
//  rst         in   1     synchronous reset, active-high
//  start       in   1     begin new hash; ignored unless IDLE
//  out_words   in   16    number of 64-bit output words to squeeze; latched on start; 0 treated as 1
//  in_valid    in   1     message word valid
//  in_data     in   64    message word, little-endian bytes (byte0 = [7:0])
//  in_bytes    in   4     valid bytes in word (8 unless in_last; 0..8 with in_last)
//  in_last     in   1     final message word
//  in_ready    out  1     controller accepts word this cycle
//  out_valid   out  1     output word valid
//  out_data    out  64    output lane
//  out_ready   in   1     consumer accepts out_data
//  busy        out  1     not IDLE
//  perm_start  out  1     one-cycle pulse to keccak_f1600 start
//  perm_in     out  1600  sponge state to permutation (lane i = [64i+:64])
//  perm_out    in   1600  permutation result
//  perm_done   in   1     one-cycle pulse; perm_out valid same cycle
// BEHAVIOUR
//  Reset: state reg=0, lane_idx=0, FSM IDLE; in_ready, out_valid, perm_start, busy=0; out_data=0.
//  States: IDLE -> ABSORB (start) ; ABSORB -> PERM (lane R-1 accepted, or padding XORed) ; PERM -> ABSORB|PAD|SQUEEZE
//   on perm_done ; PAD -> PERM ; SQUEEZE -> PERM (rate exhausted, words remain) | IDLE (last word taken).
//  R = RATE_BYTES/8. start clears state reg, lane_idx=0, latches out_words.
//  ABSORB: in_ready=1; on in_valid&in_ready XOR in_data (bytes >= in_bytes masked to 0) into lane lane_idx; 1 word/cycle.
//  Padding on in_last word with n=in_bytes: DSBYTE XORed at byte n of that lane; 0x80 XORed at rate byte
//   RATE_BYTES-1 (both XORs may hit same byte: 0x9F/0x86). If n=8, DSBYTE goes to byte0 of next lane; if that
//   lane is R, permute full block first then PAD applies DSBYTE at lane0 byte0 plus final 0x80.
//  Non-last word at lane R-1: go PERM, lane_idx=0. perm_start pulses exactly one cycle on PERM entry;
//   state reg <= perm_out on perm_done. in_ready=0 outside ABSORB.
//  SQUEEZE: out_data = lane out_idx, out_valid=1; advance on out_valid&out_ready; words_left decrements.
//   out_data/out_valid held stable while out_ready=0. Output latency: first out_valid 1 cycle after perm_done.
//  After last output word handshake: IDLE next cycle, busy=0.
//  Empty message: start then in_valid with in_last=1, in_bytes=0 (data ignored).
//  start while busy: ignored. rst mid-operation: return to reset values next edge; the external permutation
//   is also reset by rst (shared), so no stale perm_done is accepted.
//  in_bytes>8 or in_bytes!=8 without in_last: undefined; assertion flags.
// CONFIGURATION
//  KECCAK_SPONGE_ZEROIZE_EN defined: on return to IDLE (normal or abort via start-ignored path), state reg and
//   out_data are cleared to 0 on that edge; perm_in reads 0 in IDLE. Not defined: state reg retained until next start.
// STRUCTURE
//  keccak_pkg: KECCAK_LANES=25, LANE_W=64, sponge state enum, RATE_* localparams for SHA3/SHAKE variants.
//  Sub-module keccak_pad_lane (combinational): lane in, n, is_ds, is_final -> masked/padded lane XOR value.
//  keccak_f1600 instantiated by parent, not inside this block.
// TESTING
//  SHA3-256 (RATE 136, DS 06), empty msg, out_words=4 -> first out_data 64'h66D71EBFF8C6FFA7.
//  SHA3-256 "abc": in_data=64'h636261, in_bytes=3, in_last -> first out_data 64'hB225E24FA75D983A.
//  SHAKE128 empty, out_words=42 -> word0 64'h7D828FE8A42B9C7F; exactly 2 perm_start after absorb, 21 words each.
//  136-byte msg (17 full words, last in_bytes=8) -> extra PAD block, 2 perm_start total before squeeze.
//  out_ready held low 10 cycles mid-squeeze -> out_data stable, no word skipped or repeated.
//  rst asserted in PERM -> next cycle busy=0, in_ready=0, out_valid=0; new start produces correct digest.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared types and constants for the Keccak sponge controller: lane geometry,
// sponge FSM states, standard rates and domain bytes, and a byte-mask helper.
package keccak_pkg;

  localparam int KECCAK_LANES = 25;
  localparam int LANE_W       = 64;
  localparam int STATE_W      = KECCAK_LANES * LANE_W;

  localparam int RATE_SHAKE128 = 168;
  localparam int RATE_SHAKE256 = 136;
  localparam int RATE_SHA3_256 = 136;
  localparam int RATE_SHA3_512 = 72;

  localparam logic [7:0] DS_SHA3  = 8'h06;
  localparam logic [7:0] DS_SHAKE = 8'h1F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ABSORB,
    ST_PERM,
    ST_PAD,
    ST_SQUEEZE
  } sponge_state_t;

  // Bytes below n pass, the rest are zeroed; n >= 8 keeps the whole lane.
  function automatic logic [LANE_W-1:0] byte_mask(input logic [3:0] n);
    logic [LANE_W-1:0] m;
    m = '0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < n) m[8*k +: 8] = 8'hFF;
    end
    return m;
  endfunction

endpackage

// File: rtl/keccak_pad_lane.sv
// Combinational per-lane absorb value: masks the message word to its valid
// bytes, then folds in the domain byte and the final 0x80 pad bit when selected.
module keccak_pad_lane
  import keccak_pkg::*;
#(
  parameter logic [7:0] DSBYTE = DS_SHAKE
) (
  input  logic [LANE_W-1:0] lane_in,
  input  logic [3:0]        n,
  input  logic              is_ds,
  input  logic              is_final,
  output logic [LANE_W-1:0] lane_xor
);

  logic [LANE_W-1:0] ds_word;
  logic [LANE_W-1:0] fin_word;

  // The domain byte lands right after the last valid message byte.
  always_comb begin
    ds_word = '0;
    if (is_ds && (n < 4'd8)) ds_word[{n[2:0], 3'b000} +: 8] = DSBYTE;
    fin_word = is_final ? {8'h80, 56'd0} : '0;
    lane_xor = (lane_in & byte_mask(n)) ^ ds_word ^ fin_word;
  end

endmodule

// File: rtl/keccak_sponge_ctrl.sv
// Sponge controller around an external keccak_f1600: absorb, pad10*1, permute, squeeze.
// Optional macro KECCAK_SPONGE_ZEROIZE_EN clears the state and out_data on return to IDLE.
module keccak_sponge_ctrl
  import keccak_pkg::*;
#(
  parameter int         RATE_BYTES = RATE_SHAKE128,
  parameter logic [7:0] DSBYTE     = DS_SHAKE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [15:0]        out_words,
  input  logic               in_valid,
  input  logic [63:0]        in_data,
  input  logic [3:0]         in_bytes,
  input  logic               in_last,
  output logic               in_ready,
  output logic               out_valid,
  output logic [63:0]        out_data,
  input  logic               out_ready,
  output logic               busy,
  output logic               perm_start,
  output logic [STATE_W-1:0] perm_in,
  input  logic [STATE_W-1:0] perm_out,
  input  logic               perm_done
);

  localparam int         R         = RATE_BYTES / 8;
  localparam logic [4:0] LAST_LANE = 5'(R - 1);

  sponge_state_t      state;
  logic [STATE_W-1:0] sponge;
  logic [4:0]         lane_idx;
  logic [15:0]        words_left;
  logic               last_seen;
  logic               pad_pending;

  logic [STATE_W-1:0] absorb_xor;
  logic               accept;
  logic               full_last;
  logic               take;

  assign accept    = (state == ST_ABSORB) && in_valid && in_ready;
  assign full_last = in_last && (in_bytes >= 4'd8);
  assign take      = out_valid && out_ready;

  // A full last word in the final rate lane defers all padding to a separate PAD block.
  for (genvar i = 0; i < KECCAK_LANES; i++) begin : g_lane
    if (i < R) begin : g_rate
      logic word_hit;
      logic ds_hit;
      logic fin_hit;

      assign word_hit = accept && (lane_idx == 5'(i));
      assign ds_hit   = (accept && in_last &&
                         (full_last ? ((lane_idx + 5'd1) == 5'(i)) : word_hit)) ||
                        ((state == ST_PAD) && (i == 0));
      assign fin_hit  = (i == R - 1) &&
                        ((accept && in_last && !(full_last && (lane_idx == LAST_LANE))) ||
                         (state == ST_PAD));

      keccak_pad_lane #(
        .DSBYTE(DSBYTE)
      ) u_pad (
        .lane_in (word_hit ? in_data : 64'd0),
        .n       (word_hit ? in_bytes : 4'd0),
        .is_ds   (ds_hit),
        .is_final(fin_hit),
        .lane_xor(absorb_xor[LANE_W*i +: LANE_W])
      );
    end else begin : g_cap
      assign absorb_xor[LANE_W*i +: LANE_W] = '0;
    end
  end

`ifdef KECCAK_SPONGE_ZEROIZE_EN
  assign perm_in = (state == ST_IDLE) ? '0 : sponge;
`else
  assign perm_in = sponge;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      sponge      <= '0;
      lane_idx    <= '0;
      words_left  <= '0;
      last_seen   <= 1'b0;
      pad_pending <= 1'b0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      busy        <= 1'b0;
      perm_start  <= 1'b0;
    end else begin
      perm_start <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            sponge      <= '0;
            lane_idx    <= '0;
            words_left  <= (out_words == 16'd0) ? 16'd1 : out_words;
            last_seen   <= 1'b0;
            pad_pending <= 1'b0;
            in_ready    <= 1'b1;
            busy        <= 1'b1;
            state       <= ST_ABSORB;
          end
        end

        ST_ABSORB: begin
          if (accept) begin
            sponge <= sponge ^ absorb_xor;
            if (in_last || (lane_idx == LAST_LANE)) begin
              last_seen   <= in_last;
              pad_pending <= full_last && (lane_idx == LAST_LANE);
              lane_idx    <= '0;
              in_ready    <= 1'b0;
              perm_start  <= 1'b1;
              state       <= ST_PERM;
            end else begin
              lane_idx <= lane_idx + 5'd1;
            end
          end
        end

        ST_PERM: begin
          if (perm_done) begin
            sponge <= perm_out;
            if (!last_seen) begin
              in_ready <= 1'b1;
              state    <= ST_ABSORB;
            end else if (pad_pending) begin
              state <= ST_PAD;
            end else begin
              out_valid <= 1'b1;
              out_data  <= perm_out[LANE_W-1:0];
              state     <= ST_SQUEEZE;
            end
          end
        end

        ST_PAD: begin
          sponge      <= sponge ^ absorb_xor;
          pad_pending <= 1'b0;
          perm_start  <= 1'b1;
          state       <= ST_PERM;
        end

        ST_SQUEEZE: begin
          if (take) begin
            words_left <= words_left - 16'd1;
            if (words_left == 16'd1) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              lane_idx  <= '0;
              state     <= ST_IDLE;
`ifdef KECCAK_SPONGE_ZEROIZE_EN
              sponge    <= '0;
              out_data  <= '0;
`endif
            end else if (lane_idx == LAST_LANE) begin
              out_valid  <= 1'b0;
              lane_idx   <= '0;
              perm_start <= 1'b1;
              state      <= ST_PERM;
            end else begin
              lane_idx <= lane_idx + 5'd1;
              out_data <= sponge[{lane_idx + 5'd1, 6'd0} +: LANE_W];
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Only the final word may be short, and no word carries more than 8 bytes.
  a_in_bytes: assert property (@(posedge clk) disable iff (rst)
    (in_valid && in_ready) |-> ((in_bytes <= 4'd8) && (in_last || (in_bytes == 4'd8))));
`endif

endmodule
